mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 256: data-memory depth in 32-bit words, power of two.
REQ-002 Parameter DMEM_AW, default 8: word-index width, equal to log2(DMEM_WORDS).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  hold MEM/WB register and suppress memory write this cycle.
REQ-006 ReadWrite, MemtoReg, MemWrite, MemRead, Branch  in  1 each  EX/MEM control bits (ReadWrite = register-file write enable).
REQ-007 BranchTarget  in  32  branch target address from EX/MEM.
REQ-008 zflag  in  1  ALU zero flag from EX/MEM.
REQ-009 AluRes  in  32  ALU result / byte address from EX/MEM.
REQ-010 Data2  in  32  store data from EX/MEM.
REQ-011 writeReg  in  5  destination register from EX/MEM.
REQ-012 PCSrc  out  1  take-branch select to fetch.
REQ-013 PCBranch  out  32  branch target to fetch.
REQ-014 wb_ReadWrite, wb_MemtoReg  out  1 each  registered control to writeback.
REQ-015 wb_ReadData  out  32  registered load data.
REQ-016 wb_AluRes  out  32  registered ALU result.
REQ-017 wb_writeReg  out  5  registered destination register.
REQ-018 mem_err  out  1  sticky misaligned-access flag.

Function
REQ-019 PCSrc SHALL equal Branch AND zflag, combinational, and SHALL be independent of stall.
REQ-020 PCBranch SHALL equal BranchTarget, combinational.
REQ-021 Word index SHALL be AluRes[DMEM_AW+1:2]; address bits above that SHALL be ignored (wrap-around modulo DMEM_WORDS words).
REQ-022 An access is misaligned when (MemRead OR MemWrite) AND AluRes[1:0] != 0.
REQ-023 Store: when MemWrite=1, stall=0, aligned, the word at the index SHALL be written with Data2 at posedge.
REQ-024 Load: when MemRead=1, stall=0, the word at the index SHALL be sampled into wb_ReadData at posedge (1-cycle latency, EX/MEM to MEM/WB).
REQ-025 Read and write to the same index in the same cycle SHALL return the new data (write-first).
REQ-026 When stall=0 and the access is aligned, the MEM/WB register SHALL capture ReadWrite, MemtoReg, AluRes and writeReg at posedge.
REQ-027 When MemRead=0, wb_ReadData SHALL retain its previous value.
REQ-028 Misaligned access with stall=0 SHALL suppress the store, load wb_ReadWrite=0 and wb_MemtoReg=0 (bubble), and set mem_err=1.
REQ-029 mem_err SHALL remain 1 until reset.
REQ-030 When stall=1, all wb_* outputs and memory contents SHALL hold and mem_err SHALL NOT change.
REQ-031 rst SHALL take priority over stall and over all memory activity in the same cycle.

Reset
REQ-032 On rst=1 at posedge: wb_ReadWrite=0, wb_MemtoReg=0, wb_ReadData=0, wb_AluRes=0, wb_writeReg=0, mem_err=0.
REQ-033 Reset SHALL NOT clear data-memory contents and SHALL block any store in that cycle.
REQ-034 Asserting rst mid-stream SHALL leave a bubble in MEM/WB for the following cycle.

Structure
REQ-035 A shared package SHALL hold DMEM_WORDS/DMEM_AW defaults, word width 32 and register-index width 5.
REQ-036 Data memory SHALL be a sub-module dmem_sync: one write port and one synchronous write-first read port, with no reset on the array.
REQ-037 The MEM/WB register, branch logic and error flag SHALL live in mem_stage.

Verification
REQ-038 Store with AluRes=0x10, Data2=0xDEADBEEF, then load from AluRes=0x10 with MemtoReg=1 -> one cycle later wb_ReadData=0xDEADBEEF and wb_MemtoReg=1.
REQ-039 Branch=1, zflag=1, BranchTarget=0x40 -> PCSrc=1, PCBranch=0x40 in the same cycle; with zflag=0 -> PCSrc=0.
REQ-040 Load at AluRes=0x13 -> wb_ReadWrite=0, mem_err=1; a later aligned op leaves mem_err=1 until rst.
REQ-041 Load issued with stall=1 for 2 cycles -> wb_* hold the prior values; the capture occurs on the first cycle with stall=0.
REQ-042 Store to 0x400 (DMEM_WORDS=256) followed by a load from 0x0 -> returns the stored value (wrap-around).
REQ-043 rst asserted in the same cycle as a store and stall -> no write (later load returns old data) and all wb_* = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   DMEM_WORDS_DEF / DMEM_AW_DEF : default data-memory depth (words) and
//                                  word-index width
//   WORD_W                       : datapath word width
//   REG_W                        : register-file index width
//   isMisaligned()               : flags a memory access whose byte address
//                                  is not word aligned
package mem_stage_pkg;

  localparam int DMEM_WORDS_DEF = 256;
  localparam int DMEM_AW_DEF    = 8;
  localparam int WORD_W         = 32;
  localparam int REG_W          = 5;

  // Only real memory accesses can be misaligned; plain ALU ops never are.
  function automatic logic isMisaligned(input logic rd, input logic wr,
                                        input logic [1:0] byteOff);
    return (rd | wr) & (byteOff != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_sync.sv
// Single-port-address data memory with one write port and one synchronous
// read port. The read port is write-first: a read and write to the same
// index in one cycle returns the data being written.
//   clk    : clock
//   rst    : synchronous active-high reset, clears only the read register
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   re     : read enable; rdata holds its value when low
//   raddr  : read word index
//   rdata  : registered read data
module dmem_sync
  import mem_stage_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS_DEF,
  parameter int AW    = DMEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];

  // The array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory access and the MEM/WB
// pipeline register, plus a sticky misaligned-access error flag.
//   clk, rst                     : clock, synchronous active-high reset
//   stall                        : hold MEM/WB and suppress stores
//   ReadWrite, MemtoReg,
//   MemWrite, MemRead, Branch    : EX/MEM control bits
//   BranchTarget, zflag          : branch target and ALU zero flag
//   AluRes, Data2, writeReg      : ALU result / byte address, store data,
//                                  destination register
//   PCSrc, PCBranch              : combinational branch decision to fetch
//   wb_*                         : MEM/WB register outputs
//   mem_err                      : sticky misaligned-access flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int DMEM_AW    = DMEM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ReadWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Branch,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic              zflag,
  input  logic [WORD_W-1:0] AluRes,
  input  logic [WORD_W-1:0] Data2,
  input  logic [REG_W-1:0]  writeReg,
  output logic              PCSrc,
  output logic [WORD_W-1:0] PCBranch,
  output logic              wb_ReadWrite,
  output logic              wb_MemtoReg,
  output logic [WORD_W-1:0] wb_ReadData,
  output logic [WORD_W-1:0] wb_AluRes,
  output logic [REG_W-1:0]  wb_writeReg,
  output logic              mem_err
);

  logic               misalign_p0;
  logic [DMEM_AW-1:0] wordIdx_p0;
  logic               memWe_p0;
  logic               memRe_p0;
  logic               unusedAddr;

  // Branch decision does not depend on stall so fetch can redirect at once.
  assign PCSrc    = Branch & zflag;
  assign PCBranch = BranchTarget;

  // Address bits above the word index are dropped: the memory wraps.
  assign wordIdx_p0  = AluRes[DMEM_AW+1:2];
  assign unusedAddr  = ^AluRes[WORD_W-1:DMEM_AW+2];
  assign misalign_p0 = isMisaligned(MemRead, MemWrite, AluRes[1:0]);

  // Stores are blocked by reset, stall and misalignment alike.
  assign memWe_p0 = MemWrite & ~stall & ~misalign_p0 & ~rst;
  assign memRe_p0 = MemRead & ~stall;

  // ---- EX/MEM -> MEM/WB boundary ----
  dmem_sync #(
    .WORDS (DMEM_WORDS),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (memWe_p0),
    .waddr (wordIdx_p0),
    .wdata (Data2),
    .re    (memRe_p0),
    .raddr (wordIdx_p0),
    .rdata (wb_ReadData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ReadWrite <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_AluRes    <= '0;
      wb_writeReg  <= '0;
      mem_err      <= 1'b0;
    end else if (!stall) begin
      // A misaligned access becomes a bubble: no register write-back.
      wb_ReadWrite <= ReadWrite & ~misalign_p0;
      wb_MemtoReg  <= MemtoReg & ~misalign_p0;
      wb_AluRes    <= AluRes;
      wb_writeReg  <= writeReg;
      if (misalign_p0) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a long
// randomized run, all compared against a behavioural model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        ReadWrite, MemtoReg, MemWrite, MemRead, Branch, zflag;
  logic [31:0] BranchTarget, AluRes, Data2;
  logic [4:0]  writeReg;
  logic        PCSrc;
  logic [31:0] PCBranch;
  logic        wb_ReadWrite, wb_MemtoReg;
  logic [31:0] wb_ReadData, wb_AluRes;
  logic [4:0]  wb_writeReg;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ReadWrite    (ReadWrite),
    .MemtoReg     (MemtoReg),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .zflag        (zflag),
    .AluRes       (AluRes),
    .Data2        (Data2),
    .writeReg     (writeReg),
    .PCSrc        (PCSrc),
    .PCBranch     (PCBranch),
    .wb_ReadWrite (wb_ReadWrite),
    .wb_MemtoReg  (wb_MemtoReg),
    .wb_ReadData  (wb_ReadData),
    .wb_AluRes    (wb_AluRes),
    .wb_writeReg  (wb_writeReg),
    .mem_err      (mem_err)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: memory as a plain word array plus the MEM/WB fields.
  logic [31:0] mMem [256];
  logic        mRw, mMtr, mErr;
  logic [31:0] mRd, mAlu;
  logic [4:0]  mWr;
  bit          aluKnown;

  task automatic modelUpdate();
    bit          mis;
    logic [7:0]  idx;
    idx = AluRes[9:2];
    mis = (MemRead || MemWrite) && (AluRes[1:0] != 2'b00);
    if (rst) begin
      mRw = 0; mMtr = 0; mRd = 0; mAlu = 0; mWr = 0; mErr = 0;
      aluKnown = 1;
    end else if (!stall) begin
      if (MemRead)
        mRd = (MemWrite && !mis) ? Data2 : mMem[idx];
      if (MemWrite && !mis)
        mMem[idx] = Data2;
      mRw  = mis ? 1'b0 : ReadWrite;
      mMtr = mis ? 1'b0 : MemtoReg;
      mAlu = AluRes;
      mWr  = writeReg;
      // What the address/register fields hold behind a bubble is not pinned down.
      aluKnown = !mis;
      if (mis) mErr = 1;
    end
  endtask

  task automatic checkOuts();
    checkVal("wb_ReadWrite", 32'(wb_ReadWrite), 32'(mRw));
    checkVal("wb_MemtoReg", 32'(wb_MemtoReg), 32'(mMtr));
    checkVal("wb_ReadData", wb_ReadData, mRd);
    checkVal("mem_err", 32'(mem_err), 32'(mErr));
    if (aluKnown) begin
      checkVal("wb_AluRes", wb_AluRes, mAlu);
      checkVal("wb_writeReg", 32'(wb_writeReg), 32'(mWr));
    end
  endtask

  task automatic setOp(input logic mr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] d2, input logic st, input logic r);
    MemRead      = mr;
    MemWrite     = mw;
    AluRes       = alu;
    Data2        = d2;
    stall        = st;
    rst          = r;
    MemtoReg     = mr;
    ReadWrite    = 1'($urandom);
    writeReg     = 5'($urandom);
    Branch       = 1'($urandom);
    zflag        = 1'($urandom);
    BranchTarget = $urandom;
  endtask

  task automatic step();
    #1;
    checkVal("PCSrc", 32'(PCSrc), 32'(Branch & zflag));
    checkVal("PCBranch", PCBranch, BranchTarget);
    @(posedge clk);
    modelUpdate();
    #1;
    checkOuts();
  endtask

  initial begin
    logic [31:0] val, oldVal;
    logic        mr, mw;
    logic [31:0] alu;

    aluKnown = 1;
    setOp(0, 0, 0, 0, 0, 1);
    step();
    step();
    checkVal("reset_err", 32'(mem_err), 32'd0);
    checkVal("reset_rd", wb_ReadData, 32'd0);

    // Fill every word so later loads read defined data.
    for (int i = 0; i < 256; i++) begin
      setOp(0, 1, 32'(i) << 2, $urandom, 0, 0);
      step();
    end

    // Store then load at 0x10.
    setOp(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
    step();
    setOp(1, 0, 32'h10, 32'h0, 0, 0);
    step();
    checkVal("load_after_store", wb_ReadData, 32'hDEADBEEF);
    checkVal("load_memtoreg", 32'(wb_MemtoReg), 32'd1);

    // Branch decision in the same cycle.
    setOp(0, 0, 32'h0, 32'h0, 0, 0);
    Branch = 1; zflag = 1; BranchTarget = 32'h40;
    #1;
    checkVal("branch_taken", 32'(PCSrc), 32'd1);
    checkVal("branch_target", PCBranch, 32'h40);
    zflag = 0;
    #1;
    checkVal("branch_not_taken", 32'(PCSrc), 32'd0);
    step();

    // Misaligned load, sticky error, cleared only by reset.
    setOp(1, 0, 32'h13, 32'h0, 0, 0);
    ReadWrite = 1;
    step();
    checkVal("misalign_bubble", 32'(wb_ReadWrite), 32'd0);
    checkVal("misalign_err", 32'(mem_err), 32'd1);
    setOp(1, 0, 32'h14, 32'h0, 0, 0);
    step();
    checkVal("err_sticky", 32'(mem_err), 32'd1);
    setOp(0, 0, 32'h0, 32'h0, 0, 1);
    step();
    checkVal("err_cleared", 32'(mem_err), 32'd0);

    // Load held by two stall cycles, captured on the first free cycle.
    setOp(0, 0, 32'h5555_0000, 32'h0, 0, 0);
    ReadWrite = 1;
    step();
    setOp(1, 0, 32'h10, 32'h0, 1, 0);
    step();
    step();
    checkVal("stall_hold_alu", wb_AluRes, 32'h5555_0000);
    stall = 0;
    step();
    checkVal("stall_release", wb_ReadData, 32'hDEADBEEF);
    checkVal("stall_release_alu", wb_AluRes, 32'h10);

    // Address wrap-around.
    val = $urandom;
    setOp(0, 1, 32'h400, val, 0, 0);
    step();
    setOp(1, 0, 32'h0, 32'h0, 0, 0);
    step();
    checkVal("wrap_load", wb_ReadData, val);

    // Reset wins over stall and a store.
    oldVal = $urandom;
    setOp(0, 1, 32'h20, oldVal, 0, 0);
    step();
    setOp(1, 1, 32'h20, ~oldVal, 1, 1);
    step();
    checkVal("rst_rw", 32'(wb_ReadWrite), 32'd0);
    checkVal("rst_mtr", 32'(wb_MemtoReg), 32'd0);
    checkVal("rst_rd", wb_ReadData, 32'd0);
    checkVal("rst_alu", wb_AluRes, 32'd0);
    checkVal("rst_wreg", 32'(wb_writeReg), 32'd0);
    setOp(1, 0, 32'h20, 32'h0, 0, 0);
    step();
    checkVal("rst_blocks_store", wb_ReadData, oldVal);

    // Randomized traffic.
    repeat (3000) begin
      mr  = ($urandom_range(0, 2) == 0);
      mw  = ($urandom_range(0, 2) == 0);
      alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0)
        alu[1:0] = 2'($urandom_range(1, 3));
      setOp(mr, mw, alu, $urandom, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 63) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
